usb_cmd_decoder: RTL and testbench



---
 rtl/usb_cmd_pkg.sv | 43 ++++
 rtl/uart_rx_byte.sv | 98 +++++++++
 rtl/usb_cmd_decoder.sv | 141 ++++++++++++++
 tb/tb_usb_cmd_decoder.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_cmd_pkg.sv
// Shared constants for the LITTLE-USB command path: sync byte, K codes,
// header field positions and the state encodings used by receiver and parser.
package usb_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [3:0] K_SSR = 4'd0;
  localparam logic [3:0] K_PSC = 4'd1;
  localparam logic [3:0] K_MOD = 4'd2;
  localparam logic [3:0] K_ADC = 4'd3;
  localparam logic [3:0] K_CNT = 4'd4;
  localparam logic [3:0] K_SEL = 4'd5;
  localparam logic [3:0] K_DAC = 4'd6;
  localparam logic [3:0] K_MAX = K_DAC;

  localparam int HDR_Z_BIT = 7;
  localparam int HDR_A_MSB = 6;
  localparam int HDR_A_LSB = 4;
  localparam int HDR_K_MSB = 3;
  localparam int HDR_K_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DHI,
    ST_DLO,
    ST_CHK
  } parse_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] hdr,
                                           input logic [7:0] dhi,
                                           input logic [7:0] dlo);
    return hdr ^ dhi ^ dlo;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-FF synchronizer and mid-bit sampling.
// byte_valid/stop_err pulse 1 cycle after the stop-bit sample; no backpressure.
module uart_rx_byte
  import usb_cmd_pkg::*;
#(
  parameter int CLK_DIV = 347
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at half-bit was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          valid_d = sync2_q;
          err_d   = !sync2_q;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign stop_err   = err_q;
  assign rx_busy    = (state_q != RX_IDLE);

endmodule

// File: rtl/usb_cmd_decoder.sv
// Parses 5-byte A5 frames from the UART into a registered command word.
// Strobe/error 2 cycles after the CHK stop-bit sample; no backpressure.
module usb_cmd_decoder
  import usb_cmd_pkg::*;
#(
  parameter int CLK_DIV      = 347,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in,
  output logic [3:0]  cmd_k_out,
  output logic [15:0] cmd_d_out,
  output logic [2:0]  cmd_a_out,
  output logic        cmd_z_out,
  output logic        cmd_strob_out,
  output logic        frame_err_out,
  output logic        busy_out
);

  localparam int TMO_LIMIT = TIMEOUT_BITS * CLK_DIV;
  localparam int TW = $clog2(TMO_LIMIT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LIMIT - 1);

  logic       byte_valid, stop_err, rx_busy;
  logic [7:0] byte_data;

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .stop_err  (stop_err),
    .rx_busy   (rx_busy)
  );

  parse_state_e  state_q, state_d;
  logic [7:0]    hdr_q, hdr_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    cmd_k_q, cmd_k_d;
  logic [15:0]   cmd_val_q, cmd_val_d;
  logic [2:0]    cmd_a_q, cmd_a_d;
  logic          cmd_z_q, cmd_z_d;
  logic          strob_q, strob_d, err_q, err_d;

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    dhi_d     = dhi_q;
    dlo_d     = dlo_q;
    tmo_d     = tmo_q;
    cmd_k_d   = cmd_k_q;
    cmd_val_d = cmd_val_q;
    cmd_a_d   = cmd_a_q;
    cmd_z_d   = cmd_z_q;
    strob_d   = 1'b0;
    err_d     = 1'b0;

    // Silence timer: frozen while a byte is arriving on the line.
    if (state_q == ST_IDLE || byte_valid) tmo_d = '0;
    else if (!rx_busy)                    tmo_d = tmo_q + TW'(1);

    if (stop_err) begin
      if (state_q != ST_IDLE) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (byte_valid) begin
      case (state_q)
        ST_IDLE: if (byte_data == SYNC_BYTE) state_d = ST_HDR;
        ST_HDR: begin
          hdr_d   = byte_data;
          state_d = ST_DHI;
        end
        ST_DHI: begin
          dhi_d   = byte_data;
          state_d = ST_DLO;
        end
        ST_DLO: begin
          dlo_d   = byte_data;
          state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (byte_data == frame_chk(hdr_q, dhi_q, dlo_q) &&
              hdr_q[HDR_K_MSB:HDR_K_LSB] <= K_MAX) begin
            cmd_k_d   = hdr_q[HDR_K_MSB:HDR_K_LSB];
            cmd_a_d   = hdr_q[HDR_A_MSB:HDR_A_LSB];
            cmd_z_d   = hdr_q[HDR_Z_BIT];
            cmd_val_d = {dhi_q, dlo_q};
            strob_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && !rx_busy && tmo_q == TMO_LAST) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hdr_q     <= '0;
      dhi_q     <= '0;
      dlo_q     <= '0;
      tmo_q     <= '0;
      cmd_k_q   <= '0;
      cmd_val_q <= '0;
      cmd_a_q   <= '0;
      cmd_z_q   <= 1'b0;
      strob_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      dhi_q     <= dhi_d;
      dlo_q     <= dlo_d;
      tmo_q     <= tmo_d;
      cmd_k_q   <= cmd_k_d;
      cmd_val_q <= cmd_val_d;
      cmd_a_q   <= cmd_a_d;
      cmd_z_q   <= cmd_z_d;
      strob_q   <= strob_d;
      err_q     <= err_d;
    end
  end

  assign cmd_k_out     = cmd_k_q;
  assign cmd_d_out     = cmd_val_q;
  assign cmd_a_out     = cmd_a_q;
  assign cmd_z_out     = cmd_z_q;
  assign cmd_strob_out = strob_q;
  assign frame_err_out = err_q;
  assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// Self-checking bench for usb_cmd_decoder: directed scenarios plus random frames
// compared against a queue-based frame model.
module tb_usb_cmd_decoder;

  localparam int CLK_DIV      = 8;
  localparam int TIMEOUT_BITS = 40;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        rx_in = 1'b1;
  logic [3:0]  cmd_k_out;
  logic [15:0] cmd_d_out;
  logic [2:0]  cmd_a_out;
  logic        cmd_z_out, cmd_strob_out, frame_err_out, busy_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  usb_cmd_decoder #(.CLK_DIV(CLK_DIV), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .cmd_k_out    (cmd_k_out),
    .cmd_d_out    (cmd_d_out),
    .cmd_a_out    (cmd_a_out),
    .cmd_z_out    (cmd_z_out),
    .cmd_strob_out(cmd_strob_out),
    .frame_err_out(frame_err_out),
    .busy_out     (busy_out)
  );

  // Pulse monitor, sampled on the falling edge.
  int   strob_cnt = 0, err_cnt = 0, overlap_cnt = 0, wide_cnt = 0, busy_cycles = 0;
  logic strob_prev = 1'b0, err_prev = 1'b0;
  always @(negedge clk) begin
    if (cmd_strob_out === 1'b1) strob_cnt++;
    if (frame_err_out === 1'b1) err_cnt++;
    if (busy_out === 1'b1) busy_cycles++;
    if (cmd_strob_out === 1'b1 && frame_err_out === 1'b1) overlap_cnt++;
    if (cmd_strob_out === 1'b1 && strob_prev) wide_cnt++;
    if (frame_err_out === 1'b1 && err_prev) wide_cnt++;
    strob_prev = (cmd_strob_out === 1'b1);
    err_prev   = (frame_err_out === 1'b1);
  end

  // Reference model: collect bytes of a frame in a queue, judge on the fifth.
  logic [7:0]  mdl_q[$];
  logic [3:0]  m_k = '0;
  logic [15:0] m_d = '0;
  logic [2:0]  m_a = '0;
  logic        m_z = 1'b0;
  int          exp_strob = 0, exp_err = 0;

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] hdr, dhi, dlo, chk;
    if (mdl_q.size() == 0) begin
      if (b == 8'hA5) mdl_q.push_back(b);
      return;
    end
    mdl_q.push_back(b);
    if (mdl_q.size() == 5) begin
      hdr = mdl_q[1];
      dhi = mdl_q[2];
      dlo = mdl_q[3];
      chk = mdl_q[4];
      if (chk == (hdr ^ dhi ^ dlo) && hdr[3:0] <= 4'd6) begin
        m_z = hdr[7];
        m_a = hdr[6:4];
        m_k = hdr[3:0];
        m_d = {dhi, dlo};
        exp_strob++;
      end else begin
        exp_err++;
      end
      mdl_q.delete();
    end
  endfunction

  function automatic void model_abort();
    if (mdl_q.size() != 0) begin
      exp_err++;
      mdl_q.delete();
    end
  endfunction

  function automatic void model_reset();
    mdl_q.delete();
    m_k = '0;
    m_d = '0;
    m_a = '0;
    m_z = 1'b0;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap);
    @(posedge clk); #1;
    rx_in = 1'b0;
    repeat (CLK_DIV) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CLK_DIV) @(posedge clk); #1;
    end
    rx_in = stop_ok;
    repeat (CLK_DIV) @(posedge clk); #1;
    rx_in = 1'b1;
    if (stop_ok) model_byte(b);
    else model_abort();
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] c);
    send_byte(8'hA5, 1'b1, 0);
    send_byte(h, 1'b1, 0);
    send_byte(dh, 1'b1, 0);
    send_byte(dl, 1'b1, 0);
    send_byte(c, 1'b1, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    vectors++;
    if ({cmd_k_out, cmd_d_out, cmd_a_out, cmd_z_out, cmd_strob_out, frame_err_out, busy_out} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_in: outputs=%h want 0", {cmd_k_out, cmd_d_out, cmd_a_out, cmd_z_out, cmd_strob_out, frame_err_out, busy_out});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if ({cmd_k_out, cmd_d_out, cmd_a_out, cmd_z_out, busy_out} !== 25'd0 || err_cnt !== 0 || strob_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_out: outputs=%h err=%0d strob=%0d want 0", {cmd_k_out, cmd_d_out, cmd_a_out, cmd_z_out, busy_out}, err_cnt, strob_cnt);
    end
  endtask

  task automatic test_valid_frame();
    send_frame(8'h06, 8'h12, 8'h34, 8'h20);
    vectors++;
    if (strob_cnt !== 1 || exp_strob !== 1) begin
      miscompares++;
      $display("FAIL valid_strobe: got %0d want 1", strob_cnt);
    end
    vectors++;
    if ({cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out} !== {1'b0, 3'd0, 4'd6, 16'h1234}) begin
      miscompares++;
      $display("FAIL valid_fields: got z=%0d a=%0d k=%0d d=%h want 0 0 6 1234", cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out);
    end
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++;
      $display("FAIL valid_no_err: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_field_packing();
    send_frame(8'hB1, 8'h00, 8'h01, 8'hB0);
    vectors++;
    if ({cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out} !== {1'b1, 3'd3, 4'd1, 16'h0001}) begin
      miscompares++;
      $display("FAIL pack_fields: got z=%0d a=%0d k=%0d d=%h want 1 3 1 0001", cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out);
    end
    vectors++;
    if (strob_cnt !== exp_strob) begin
      miscompares++;
      $display("FAIL pack_strobe: got %0d want %0d", strob_cnt, exp_strob);
    end
    send_frame(8'hB1, 8'h00, 8'h01, 8'hB1);
    vectors++;
    if (err_cnt !== exp_err || strob_cnt !== exp_strob) begin
      miscompares++;
      $display("FAIL badchk_pulses: err=%0d strob=%0d want %0d %0d", err_cnt, strob_cnt, exp_err, exp_strob);
    end
    vectors++;
    if ({cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out} !== {1'b1, 3'd3, 4'd1, 16'h0001}) begin
      miscompares++;
      $display("FAIL badchk_hold: got z=%0d a=%0d k=%0d d=%h want 1 3 1 0001", cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out);
    end
  endtask

  task automatic test_k_range();
    int busy0, err0;
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    vectors++;
    if (err_cnt !== exp_err || strob_cnt !== exp_strob) begin
      miscompares++;
      $display("FAIL k_range: err=%0d strob=%0d want %0d %0d", err_cnt, strob_cnt, exp_err, exp_strob);
    end
    busy0 = busy_cycles;
    err0  = err_cnt;
    send_byte(8'h00, 1'b1, 3);
    send_byte(8'hFF, 1'b1, 3);
    send_byte(8'h12, 1'b1, 3);
    @(posedge clk); #1;
    rx_in = 1'b0;
    repeat (2) @(posedge clk); #1;
    rx_in = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
    vectors++;
    if (busy_cycles !== busy0) begin
      miscompares++;
      $display("FAIL garbage_busy: busy cycles %0d want 0", busy_cycles - busy0);
    end
    vectors++;
    if (err_cnt !== err0) begin
      miscompares++;
      $display("FAIL garbage_err: errors %0d want 0", err_cnt - err0);
    end
  endtask

  task automatic test_stop_err();
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h06, 1'b1, 0);
    send_byte(8'h12, 1'b0, 4);
    repeat (2) @(negedge clk);
    vectors++;
    if (err_cnt !== exp_err) begin
      miscompares++;
      $display("FAIL stop_err_pulse: got %0d want %0d", err_cnt, exp_err);
    end
    vectors++;
    if (busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_err_idle: busy=%0d want 0", busy_out);
    end
    send_frame(8'h06, 8'h12, 8'h34, 8'h20);
    vectors++;
    if (strob_cnt !== exp_strob || {cmd_k_out, cmd_d_out} !== {4'd6, 16'h1234}) begin
      miscompares++;
      $display("FAIL stop_err_recover: strob=%0d k=%0d d=%h want %0d 6 1234", strob_cnt, cmd_k_out, cmd_d_out, exp_strob);
    end
  endtask

  task automatic test_timeout();
    int err0, waited;
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h06, 1'b1, 0);
    err0   = err_cnt;
    waited = 0;
    while (err_cnt == err0 && waited < TIMEOUT_BITS * CLK_DIV + 80) begin
      @(negedge clk);
      waited++;
    end
    model_abort();
    vectors++;
    if (err_cnt !== err0 + 1 || waited < (TIMEOUT_BITS - 1) * CLK_DIV || waited > TIMEOUT_BITS * CLK_DIV + 16) begin
      miscompares++;
      $display("FAIL timeout_fire: errors=%0d after %0d cycles want 1 near %0d", err_cnt - err0, waited, TIMEOUT_BITS * CLK_DIV);
    end
    vectors++;
    if (busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_busy: busy=%0d want 0", busy_out);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (err_cnt !== exp_err) begin
      miscompares++;
      $display("FAIL timeout_single: got %0d want %0d", err_cnt, exp_err);
    end
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h35, 1'b1, (TIMEOUT_BITS - 1) * CLK_DIV);
    send_byte(8'hAB, 1'b1, 0);
    send_byte(8'hCD, 1'b1, 0);
    send_byte(8'h35 ^ 8'hAB ^ 8'hCD, 1'b1, 4);
    @(negedge clk);
    vectors++;
    if (err_cnt !== exp_err || strob_cnt !== exp_strob) begin
      miscompares++;
      $display("FAIL gap_no_abort: err=%0d strob=%0d want %0d %0d", err_cnt, strob_cnt, exp_err, exp_strob);
    end
    vectors++;
    if ({cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out} !== {1'b0, 3'd3, 4'd5, 16'hABCD}) begin
      miscompares++;
      $display("FAIL gap_fields: got z=%0d a=%0d k=%0d d=%h want 0 3 5 abcd", cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h06, 1'b1, 0);
    send_byte(8'h12, 1'b1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_k_out, cmd_d_out, cmd_a_out, cmd_z_out, busy_out} !== 25'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got %h want 0", {cmd_k_out, cmd_d_out, cmd_a_out, cmd_z_out, busy_out});
    end
    vectors++;
    if (err_cnt !== exp_err) begin
      miscompares++;
      $display("FAIL rst_mid_no_err: got %0d want %0d", err_cnt, exp_err);
    end
    send_frame(8'h92, 8'h5A, 8'hA5, 8'h92 ^ 8'h5A ^ 8'hA5);
    vectors++;
    if (strob_cnt !== exp_strob || {cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out} !== {1'b1, 3'd1, 4'd2, 16'h5AA5}) begin
      miscompares++;
      $display("FAIL rst_mid_recover: strob=%0d z=%0d a=%0d k=%0d d=%h want %0d 1 1 2 5aa5", strob_cnt, cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out, exp_strob);
    end
  endtask

  task automatic test_random();
    logic [7:0] fr[5];
    logic [7:0] g, flip;
    int ngarb, errpos;
    logic ok;
    for (int n = 0; n < 30; n++) begin
      ngarb = $urandom_range(0, 2);
      for (int j = 0; j < ngarb; j++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 1'b1, $urandom_range(0, 12));
      end
      fr[0] = 8'hA5;
      fr[1] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7))};
      fr[2] = 8'($urandom_range(0, 255));
      fr[3] = 8'($urandom_range(0, 255));
      fr[4] = fr[1] ^ fr[2] ^ fr[3];
      if ($urandom_range(0, 3) == 0) begin
        flip  = 8'h01 << $urandom_range(0, 7);
        fr[4] = fr[4] ^ flip;
      end
      errpos = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
      for (int j = 0; j < 5; j++) begin
        ok = !(errpos != 0 && j == errpos);
        send_byte(fr[j], ok, $urandom_range(0, 15));
        if (!ok) break;
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (strob_cnt !== exp_strob) begin
        miscompares++;
        $display("FAIL rand_strobe[%0d]: got %0d want %0d", n, strob_cnt, exp_strob);
      end
      vectors++;
      if (err_cnt !== exp_err) begin
        miscompares++;
        $display("FAIL rand_err[%0d]: got %0d want %0d", n, err_cnt, exp_err);
      end
      vectors++;
      if ({cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out} !== {m_z, m_a, m_k, m_d}) begin
        miscompares++;
        $display("FAIL rand_fields[%0d]: got %h want %h", n, {cmd_z_out, cmd_a_out, cmd_k_out, cmd_d_out}, {m_z, m_a, m_k, m_d});
      end
      vectors++;
      if (busy_out !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_busy[%0d]: got %0d want 0", n, busy_out);
      end
    end
  endtask

  task automatic test_pulse_shape();
    vectors++;
    if (overlap_cnt !== 0) begin
      miscompares++;
      $display("FAIL pulse_overlap: got %0d cycles want 0", overlap_cnt);
    end
    vectors++;
    if (wide_cnt !== 0) begin
      miscompares++;
      $display("FAIL pulse_width: got %0d extended cycles want 0", wide_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_field_packing();
    test_k_range();
    test_stop_err();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    test_pulse_shape();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
